// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//
// Shares a single (A_WIDTH)-bit + (B_WIDTH)-bit unsigned adder among NUM_REQ
// requesters. Requests are arbitrated round-robin. The registered sum is
// returned to the requester that won, through a valid/ready response
// handshake. When the owner keeps resp_ready high, one add completes per cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester request accepted this cycle (at most one bit set)
//   req_a       packed operand A, requester i at [i*A_WIDTH +: A_WIDTH]
//   req_b       packed operand B, requester i at [i*B_WIDTH +: B_WIDTH]
//   resp_valid  one-hot result valid for the owning requester
//   resp_ready  per-requester result accept (only the owner's bit is used)
//   resp_sum    registered sum, broadcast to all requesters
//   resp_carry  carry out of the A_WIDTH-bit addition (resp_sum MSB)

module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned A_WIDTH = 63,
  parameter int unsigned B_WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [A_WIDTH:0]             resp_sum,
  output logic                         resp_carry
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so last_grant + 1 + k (at most 2*NUM_REQ-1) never overflows.
  localparam int unsigned CandW = IdxW + 1;
  localparam int unsigned SumW  = A_WIDTH + 1;

  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [0:0] {
    StIdle,
    StResult
  } state_e;

  state_e               state_q, state_d;
  idx_t                 owner_q, owner_d;
  idx_t                 last_q, last_d;
  logic [NUM_REQ-1:0]   valid_q, valid_d;
  logic [SumW-1:0]      sum_q, sum_d;

  idx_t                 winner;
  logic                 any_valid;
  logic [CandW-1:0]     cand;
  logic [NUM_REQ-1:0]   winner_oh;
  logic                 window_open;
  logic                 handshake;
  logic [A_WIDTH-1:0]   a_sel;
  logic [B_WIDTH-1:0]   b_sel;
  logic [SumW-1:0]      sum_new;

  // Round-robin search: first valid requester starting just after last_q.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = CandW'(last_q) + CandW'(1) + CandW'(k);
      if (cand >= CandW'(NUM_REQ)) begin
        cand = cand - CandW'(NUM_REQ);
      end
      if (!any_valid && req_valid[cand[IdxW-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[IdxW-1:0];
      end
    end
  end

  // Operand mux and one-hot decode of the winner.
  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    winner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == idx_t'(i)) begin
        a_sel        = req_a[i*A_WIDTH +: A_WIDTH];
        b_sel        = req_b[i*B_WIDTH +: B_WIDTH];
        winner_oh[i] = 1'b1;
      end
    end
  end

  // Zero-extend both operands so the carry lands in the MSB instead of wrapping.
  assign sum_new = {1'b0, a_sel} + SumW'(b_sel);

  // A held result blocks new work unless its owner drains it this cycle.
  assign window_open = (state_q == StIdle) || resp_ready[owner_q];
  // Gating with rst_n keeps req_ready low throughout reset.
  assign handshake   = rst_n && window_open && any_valid;
  assign req_ready   = handshake ? winner_oh : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StResult;
          owner_d = winner;
          last_d  = winner;
          valid_d = winner_oh;
          sum_d   = sum_new;
        end
      end
      StResult: begin
        if (handshake) begin
          // Drain and refill in the same cycle.
          owner_d = winner;
          last_d  = winner;
          valid_d = winner_oh;
          sum_d   = sum_new;
        end else if (resp_ready[owner_q]) begin
          state_d = StIdle;
          valid_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= idx_t'(NUM_REQ - 1);
      valid_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_sum   = sum_q;
  assign resp_carry = sum_q[SumW-1];

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

  localparam int AW = 63;
  localparam int BW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0]      v2, rdy2, rv2, rr2;
  logic [2*AW-1:0] a2;
  logic [2*BW-1:0] b2;
  logic [63:0]     sum2;
  logic            c2;

  // Four-requester instance
  logic [3:0]      v4, rdy4, rv4, rr4;
  logic [4*AW-1:0] a4;
  logic [4*BW-1:0] b4;
  logic [63:0]     sum4;
  logic            c4;

  adder_share_arbiter #(.NUM_REQ(2), .A_WIDTH(AW), .B_WIDTH(BW)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (v2),
    .req_ready  (rdy2),
    .req_a      (a2),
    .req_b      (b2),
    .resp_valid (rv2),
    .resp_ready (rr2),
    .resp_sum   (sum2),
    .resp_carry (c2)
  );

  adder_share_arbiter #(.NUM_REQ(4), .A_WIDTH(AW), .B_WIDTH(BW)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (v4),
    .req_ready  (rdy4),
    .req_a      (a4),
    .req_b      (b4),
    .resp_valid (rv4),
    .resp_ready (rr4),
    .resp_sum   (sum4),
    .resp_carry (c4)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One row per cycle for the 2-requester instance: inputs, expected
  // combinational req_ready, expected registered outputs during that cycle.
  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rr;
    logic [62:0] a0;
    logic [62:0] a1;
    logic [10:0] b0;
    logic [10:0] b1;
    logic [1:0]  rdy;
    logic [1:0]  rv;
    logic [63:0] sum;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  initial begin
    // alternation after reset, requester 0 first
    tbl[0]  = '{2'b00, 2'b11, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b00, 64'h0};
    tbl[1]  = '{2'b11, 2'b11, 63'h10,  63'h20,  11'h1, 11'h1, 2'b01, 2'b00, 64'h0};
    tbl[2]  = '{2'b11, 2'b11, 63'h30,  63'h40,  11'h1, 11'h1, 2'b10, 2'b01, 64'h11};
    tbl[3]  = '{2'b11, 2'b11, 63'h50,  63'h60,  11'h1, 11'h1, 2'b01, 2'b10, 64'h41};
    tbl[4]  = '{2'b11, 2'b11, 63'h70,  63'h80,  11'h2, 11'h3, 2'b10, 2'b01, 64'h51};
    tbl[5]  = '{2'b00, 2'b11, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b10, 64'h83};
    tbl[6]  = '{2'b00, 2'b11, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b00, 64'h83};
    // maximum operands: carry out
    tbl[7]  = '{2'b01, 2'b11, 63'h7FFF_FFFF_FFFF_FFFF, 63'h0, 11'h7FF, 11'h0,
                2'b01, 2'b00, 64'h83};
    tbl[8]  = '{2'b00, 2'b11, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b01,
                64'h8000_0000_0000_07FE};
    // back-pressure: owner 1 stalls three cycles
    tbl[9]  = '{2'b11, 2'b00, 63'h0,   63'h200, 11'h0, 11'h5, 2'b10, 2'b00,
                64'h8000_0000_0000_07FE};
    tbl[10] = '{2'b11, 2'b00, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b10, 64'h205};
    tbl[11] = '{2'b11, 2'b00, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b10, 64'h205};
    tbl[12] = '{2'b11, 2'b00, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b10, 64'h205};
    tbl[13] = '{2'b11, 2'b10, 63'h100, 63'h0,   11'h0, 11'h0, 2'b01, 2'b10, 64'h205};
    // wrong-owner accept is ignored
    tbl[14] = '{2'b00, 2'b00, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b01, 64'h100};
    tbl[15] = '{2'b10, 2'b10, 63'h0,   63'h7,   11'h0, 11'h1, 2'b00, 2'b01, 64'h100};
    tbl[16] = '{2'b00, 2'b10, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b01, 64'h100};
    tbl[17] = '{2'b00, 2'b01, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b01, 64'h100};
    tbl[18] = '{2'b00, 2'b01, 63'h0,   63'h0,   11'h0, 11'h0, 2'b00, 2'b00, 64'h100};

    v2 = 2'b11; rr2 = 2'b11; a2 = '0; b2 = '0;
    v4 = 4'b1111; rr4 = 4'b1111; a4 = '0; b4 = '0;

    // outputs stay zero while in reset, even with requests pending
    #2;
    check("rst rdy2", 64'(rdy2), 64'h0);
    check("rst rv2", 64'(rv2), 64'h0);
    check("rst sum2", sum2, 64'h0);
    check("rst c2", 64'(c2), 64'h0);
    check("rst rdy4", 64'(rdy4), 64'h0);
    check("rst rv4", 64'(rv4), 64'h0);
    v4 = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v2  = tbl[i].v;
      rr2 = tbl[i].rr;
      a2  = {tbl[i].a1, tbl[i].a0};
      b2  = {tbl[i].b1, tbl[i].b0};
      #3;
      check($sformatf("row%0d rdy", i), 64'(rdy2), 64'(tbl[i].rdy));
      check($sformatf("row%0d rv", i), 64'(rv2), 64'(tbl[i].rv));
      check($sformatf("row%0d sum", i), sum2, tbl[i].sum);
      check($sformatf("row%0d carry", i), 64'(c2), 64'(tbl[i].sum[63]));
      @(posedge clk);
      #1;
    end

    // asynchronous reset while holding a result
    v2 = 2'b10; rr2 = 2'b00; a2 = {63'h7, 63'h0}; b2 = {11'h1, 11'h0};
    @(posedge clk);
    #1;
    check("pre-rst rv", 64'(rv2), 64'h2);
    check("pre-rst sum", sum2, 64'h8);
    #2 rst_n = 1'b0;
    #1;
    check("async rst rv", 64'(rv2), 64'h0);
    check("async rst sum", sum2, 64'h0);
    check("async rst rdy", 64'(rdy2), 64'h0);
    v2 = 2'b11; rr2 = 2'b11; a2 = {63'h0, 63'h9}; b2 = {11'h0, 11'h1};
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post-rst rdy", 64'(rdy2), 64'h1);
    @(posedge clk);
    #1;
    check("post-rst rv", 64'(rv2), 64'h1);
    check("post-rst sum", sum2, 64'hA);
    v2 = 2'b00;

    // four requesters: only 3, then wrap-around to 0, then back to 3
    rr4 = 4'b1111;
    v4 = 4'b1000;
    a4 = '0; b4 = '0;
    a4[3*AW +: AW] = 63'd5;
    b4[3*BW +: BW] = 11'd3;
    #1;
    check("n4 rdy3", 64'(rdy4), 64'h8);
    @(posedge clk);
    #1;
    check("n4 rv3", 64'(rv4), 64'h8);
    check("n4 sum3", sum4, 64'h8);
    check("n4 carry3", 64'(c4), 64'h0);
    v4 = 4'b1001;
    a4[0 +: AW] = 63'h123;
    b4[0 +: BW] = 11'h10;
    #1;
    check("n4 wrap rdy", 64'(rdy4), 64'h1);
    @(posedge clk);
    #1;
    check("n4 wrap rv", 64'(rv4), 64'h1);
    check("n4 wrap sum", sum4, 64'h133);
    #1;
    check("n4 next rdy", 64'(rdy4), 64'h8);
    @(posedge clk);
    #1;
    check("n4 next rv", 64'(rv4), 64'h8);
    check("n4 next sum", sum4, 64'h8);
    v4 = '0;
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 63-bit + 11-bit unsigned add datapath (63-bit A plus zero-extended 11-bit B, 64-bit sum) among NUM_REQ requesters.
- Typical requesters are the FP exponent/mantissa adjust stages.
- Arbitration is round-robin with a valid/ready request handshake.
- The registered result is returned with a valid/ready response handshake to the granted requester only.
- Sits between the FP pipeline stages and the shared adder; sustains one add per cycle when not back-pressured.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- A_WIDTH, 63, width of operand A (fixed at 63 in this design).
- B_WIDTH, 11, width of operand B; zero-extended to A_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accepted this cycle (at most one bit set).
- req_a  input  NUM_REQ*63  packed operand A; requester i occupies bits [i*63 +: 63].
- req_b  input  NUM_REQ*11  packed operand B; requester i occupies bits [i*11 +: 11].
- resp_valid  output  NUM_REQ  one-hot result valid, set for the owning requester.
- resp_ready  input  NUM_REQ  per-requester result accept.
- resp_sum  output  64  registered sum, broadcast to all requesters.
- resp_carry  output  1  equal to resp_sum[63], the carry out of 63-bit addition.

Behaviour:
- Arithmetic: sum = {1'b0, A} + {53'b0, B}.
  - 64-bit result; never truncates or wraps.
- State machine, two states.
  - IDLE: no result held.
  - RESULT: result held for owner index `owner`.
- Reset (async, rst_n low):
  - state = IDLE.
  - resp_valid = 0, resp_sum = 0, resp_carry = 0, owner = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has highest priority after reset.
  - A pending result is discarded; outputs clear immediately, without waiting for clk.
- Grant selection (combinational, every cycle):
  - The winner is the first i with req_valid[i]=1, searching from last_grant+1 upward modulo NUM_REQ.
- Accept window:
  - Open when state==IDLE.
  - Also open when state==RESULT and resp_ready[owner]==1 (same-cycle drain and refill).
- req_ready:
  - req_ready[winner]=1 only when the accept window is open and some req_valid is high.
  - All other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid and resp_ready.
- On a request handshake (req_valid[w] & req_ready[w]) at a clock edge:
  - resp_sum <= sum of requester w's operands; resp_carry follows.
  - resp_valid <= one-hot(w); owner <= w; last_grant <= w.
  - state <= RESULT.
- Latency: 1 cycle from request handshake to resp_valid.
- Throughput: 1 result/cycle when the owner holds resp_ready high.
- In RESULT with resp_ready[owner]=1 and no new handshake: resp_valid <= 0, state <= IDLE.
  - resp_sum keeps its last value; it is don't-care but must not be X.
- In RESULT with resp_ready[owner]=0:
  - resp_sum, resp_carry, resp_valid and owner hold stable.
  - req_ready is all 0.
- resp_ready bits of non-owners are ignored.
- A requester may drop req_valid before its handshake; grant is re-evaluated every cycle with no penalty.
- last_grant updates only on a handshake.
- A requester holding req_valid high is granted within NUM_REQ handshakes, so there is no starvation.

Test Plan:
- Reset, then req0 with A=63'h7FFF_FFFF_FFFF_FFFF, B=11'h7FF, resp_ready=all 1 -> next cycle resp_valid=2'b01, resp_sum=64'h8000_0000_0000_07FE, resp_carry=1. While rst_n is low, all outputs are 0.
- NUM_REQ=2, req_valid=2'b11 held, resp_ready=2'b11, A=i, B=1 per requester -> req_ready alternates 01,10,01,10 starting with requester 0. resp_valid follows one cycle later. One result per cycle; each sum equals A+1.
- Back-pressure: the result is held and resp_ready[owner]=0 for 3 cycles while both req_valid are high -> resp_sum/resp_valid stable, req_ready=0. In the 4th cycle resp_ready rises -> the next requester is accepted in that same cycle.
- Wrong-owner accept: owner=0, resp_ready=2'b10 -> result held, state stays RESULT. Then resp_ready=2'b01 with no requests -> resp_valid=0 next cycle.
- Reset mid-operation: rst_n driven low asynchronously while in RESULT -> resp_valid=0 before the next clk edge. After release, with both requesters valid, requester 0 is granted first.
- NUM_REQ=4, only req_valid[3], A=5, B=3 -> req_ready=4'b1000, resp_sum=8, resp_carry=0. Then req_valid=4'b1001 -> requester 0 is granted next (wrap-around).
